// File: rtl/if_pkg.sv
// Shared definitions for the fetch-stage program counter.
//   pc_state_e      : PC sequencer state (BOOT hold-off, RUN)
//   DEF_* constants : default width, vectors, increment and boot hold-off
package if_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

  localparam int unsigned DEF_PC_WIDTH     = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'hBFC0_0380;
  localparam int unsigned DEF_PC_INC       = 4;
  localparam int unsigned DEF_BOOT_WAIT    = 2;

endpackage

// File: rtl/if_pc_next_sel.sv
// Combinational priority select of the next PC and the pending-redirect latch.
// Priority: exception > eret > branch > jump > pending replay > sequential > hold.
//   i_pc, i_pc_seq        : current PC and PC + increment
//   i_stall               : hazard stall
//   i_exception, i_eret   : trap entry / return (override stall)
//   i_epc                 : eret target
//   i_branch, i_br_tgt    : branch redirect
//   i_jump, i_jmp_tgt     : jump redirect
//   i_pend, i_pend_tgt    : current pending latch
//   o_next_pc             : PC for the next edge
//   o_next_pend(_tgt)     : pending latch for the next edge
module if_pc_next_sel #(
  parameter int unsigned           PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0]   EXC_VECTOR = '0
) (
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic [PC_WIDTH-1:0] i_pc_seq,
  input  logic                i_stall,
  input  logic                i_exception,
  input  logic                i_eret,
  input  logic [PC_WIDTH-1:0] i_epc,
  input  logic                i_branch,
  input  logic [PC_WIDTH-1:0] i_br_tgt,
  input  logic                i_jump,
  input  logic [PC_WIDTH-1:0] i_jmp_tgt,
  input  logic                i_pend,
  input  logic [PC_WIDTH-1:0] i_pend_tgt,
  output logic [PC_WIDTH-1:0] o_next_pc,
  output logic                o_next_pend,
  output logic [PC_WIDTH-1:0] o_next_pend_tgt
);

  always_comb begin
    o_next_pc       = i_pc;
    o_next_pend     = i_pend;
    o_next_pend_tgt = i_pend_tgt;
    if (i_exception) begin
      o_next_pc   = EXC_VECTOR;
      o_next_pend = 1'b0;
    end else if (i_eret) begin
      o_next_pc   = i_epc;
      o_next_pend = 1'b0;
    end else if (i_branch) begin
      // A stalled redirect is parked; a newer one overwrites an older one.
      if (!i_stall) begin
        o_next_pc   = i_br_tgt;
        o_next_pend = 1'b0;
      end else begin
        o_next_pend     = 1'b1;
        o_next_pend_tgt = i_br_tgt;
      end
    end else if (i_jump) begin
      if (!i_stall) begin
        o_next_pc   = i_jmp_tgt;
        o_next_pend = 1'b0;
      end else begin
        o_next_pend     = 1'b1;
        o_next_pend_tgt = i_jmp_tgt;
      end
    end else if (i_pend && !i_stall) begin
      o_next_pc   = i_pend_tgt;
      o_next_pend = 1'b0;
    end else if (!i_stall) begin
      o_next_pc = i_pc_seq;
    end
  end

endmodule

// File: rtl/if_pc_unit.sv
// Fetch-stage program counter with reset vector, boot hold-off, prioritised
// redirects, pending-redirect latch and misalignment flag.
//   Clk, Rst (async, active-high)
//   pc_stall, Exception, Eret/Epc, Branch_Taken/Branch_Target, Jump/Jump_Target
//   PC_IF (reg), PC_Plus4_IF (comb), PC_Valid (reg), Redirect_Pending (reg),
//   Misaligned (comb)
module if_pc_unit
  import if_pkg::*;
#(
  parameter int unsigned         PC_WIDTH     = DEF_PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEF_RESET_VECTOR),
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = PC_WIDTH'(DEF_EXC_VECTOR),
  parameter int unsigned         PC_INC       = DEF_PC_INC,
  parameter int unsigned         BOOT_WAIT    = DEF_BOOT_WAIT
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                pc_stall,
  input  logic                Exception,
  input  logic                Eret,
  input  logic [PC_WIDTH-1:0] Epc,
  input  logic                Branch_Taken,
  input  logic [PC_WIDTH-1:0] Branch_Target,
  input  logic                Jump,
  input  logic [PC_WIDTH-1:0] Jump_Target,
  output logic [PC_WIDTH-1:0] PC_IF,
  output logic [PC_WIDTH-1:0] PC_Plus4_IF,
  output logic                PC_Valid,
  output logic                Redirect_Pending,
  output logic                Misaligned
);

  localparam int CNT_W = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT + 1) : 1;

  pc_state_e           r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [PC_WIDTH-1:0] r_pc, r_pend_tgt;
  logic                r_valid, r_pend;
  logic [PC_WIDTH-1:0] w_pc_seq, w_next_pc, w_next_pend_tgt;
  logic                w_next_pend, w_run, w_boot_dec;

  // Carry out of the increment is dropped, so the PC wraps to zero.
  assign w_pc_seq = r_pc + PC_WIDTH'(PC_INC);

  if_pc_next_sel #(
    .PC_WIDTH   (PC_WIDTH),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_sel (
    .i_pc            (r_pc),
    .i_pc_seq        (w_pc_seq),
    .i_stall         (pc_stall),
    .i_exception     (Exception),
    .i_eret          (Eret),
    .i_epc           (Epc),
    .i_branch        (Branch_Taken),
    .i_br_tgt        (Branch_Target),
    .i_jump          (Jump),
    .i_jmp_tgt       (Jump_Target),
    .i_pend          (r_pend),
    .i_pend_tgt      (r_pend_tgt),
    .o_next_pc       (w_next_pc),
    .o_next_pend     (w_next_pend),
    .o_next_pend_tgt (w_next_pend_tgt)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ST_BOOT;
    else     r_state <= w_state_next;
  end

  // The boot edge that moves the count from 1 to 0 is the one that enters RUN;
  // a zero hold-off therefore enters RUN on the first edge after release.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BOOT: if (r_cnt <= CNT_W'(1)) w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_BOOT;
    endcase
  end

  always_comb begin
    w_run      = (r_state == ST_RUN);
    w_boot_dec = (r_state == ST_BOOT) && (r_cnt != '0);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_pc       <= RESET_VECTOR;
      r_valid    <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
      r_cnt      <= CNT_W'(BOOT_WAIT);
    end else begin
      r_valid <= (w_state_next == ST_RUN);
      if (w_boot_dec) r_cnt <= r_cnt - CNT_W'(1);
      if (w_run) begin
        r_pc       <= w_next_pc;
        r_pend     <= w_next_pend;
        r_pend_tgt <= w_next_pend_tgt;
      end
    end
  end

  assign PC_IF            = r_pc;
  assign PC_Plus4_IF      = w_pc_seq;
  assign PC_Valid         = r_valid;
  assign Redirect_Pending = r_pend;
  assign Misaligned       = |r_pc[1:0];

endmodule

// File: tb/tb_if_pc_unit.sv
module tb_if_pc_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        pc_stall = 1'b0, Exception = 1'b0, Eret = 1'b0;
  logic        Branch_Taken = 1'b0, Jump = 1'b0;
  logic [31:0] Epc = '0, Branch_Target = '0, Jump_Target = '0;
  logic [31:0] PC_IF, PC_Plus4_IF;
  logic        PC_Valid, Redirect_Pending, Misaligned;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        v;
    logic        p;
  } exp_t;

  exp_t sb[$];

  if_pc_unit dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .pc_stall         (pc_stall),
    .Exception        (Exception),
    .Eret             (Eret),
    .Epc              (Epc),
    .Branch_Taken     (Branch_Taken),
    .Branch_Target    (Branch_Target),
    .Jump             (Jump),
    .Jump_Target      (Jump_Target),
    .PC_IF            (PC_IF),
    .PC_Plus4_IF      (PC_Plus4_IF),
    .PC_Valid         (PC_Valid),
    .Redirect_Pending (Redirect_Pending),
    .Misaligned       (Misaligned)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_now(input exp_t e);
    logic [31:0] p4;
    p4 = e.pc + 32'd4;
    chk({e.tag, ".pc"},    PC_IF, e.pc);
    chk({e.tag, ".plus4"}, PC_Plus4_IF, p4);
    chk({e.tag, ".valid"}, {31'd0, PC_Valid}, {31'd0, e.v});
    chk({e.tag, ".pend"},  {31'd0, Redirect_Pending}, {31'd0, e.p});
    chk({e.tag, ".mis"},   {31'd0, Misaligned}, {31'd0, (e.pc[1:0] != 2'b00)});
  endtask

  // Inputs are already driven; expectation queued, one edge taken, then compared.
  task automatic step(input string tag, input logic [31:0] pc, input logic v, input logic p);
    exp_t e;
    sb.push_back('{tag, pc, v, p});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check_now(e);
  endtask

  task automatic idle();
    pc_stall = 0; Exception = 0; Eret = 0; Branch_Taken = 0; Jump = 0;
  endtask

  initial begin
    exp_t e;
    repeat (2) @(posedge Clk);
    #1;
    e = '{"reset", 32'hBFC0_0000, 1'b0, 1'b0};
    check_now(e);

    // Boot hold-off: redirects during BOOT must be ignored.
    Rst = 0;
    Jump = 1; Jump_Target = 32'h0040_0102; Exception = 1; Branch_Taken = 1;
    Branch_Target = 32'h1234_5670;
    step("boot1", 32'hBFC0_0000, 0, 0);
    step("boot2", 32'hBFC0_0000, 1, 0);
    idle();
    step("seq1", 32'hBFC0_0004, 1, 0);
    step("seq2", 32'hBFC0_0008, 1, 0);
    step("seq3", 32'hBFC0_000C, 1, 0);
    step("seq4", 32'hBFC0_0010, 1, 0);

    // Stalled branch parks in the pending latch.
    pc_stall = 1; Branch_Taken = 1; Branch_Target = 32'h0040_0100;
    step("stbr", 32'hBFC0_0010, 1, 1);
    Branch_Taken = 0;
    step("hold1", 32'hBFC0_0010, 1, 1);
    step("hold2", 32'hBFC0_0010, 1, 1);
    pc_stall = 0;
    step("replay", 32'h0040_0100, 1, 0);
    step("after", 32'h0040_0104, 1, 0);

    // Latest stalled redirect wins.
    pc_stall = 1; Branch_Taken = 1; Branch_Target = 32'h0000_0100;
    step("latch_br", 32'h0040_0104, 1, 1);
    Branch_Taken = 0; Jump = 1; Jump_Target = 32'h0000_0200;
    step("latch_jmp", 32'h0040_0104, 1, 1);
    idle();
    step("latest", 32'h0000_0200, 1, 0);

    // Exception overrides stall and clears an occupied latch.
    pc_stall = 1; Branch_Taken = 1; Branch_Target = 32'h0000_0300;
    step("pend_pre", 32'h0000_0200, 1, 1);
    Exception = 1;
    step("exc", 32'hBFC0_0380, 1, 0);
    Exception = 0; Branch_Taken = 0; Eret = 1; Epc = 32'h0040_0020;
    step("eret", 32'h0040_0020, 1, 0);
    idle();

    // Unstalled branch beats the pending replay and clears the latch.
    pc_stall = 1; Branch_Taken = 1; Branch_Target = 32'h0000_0500;
    step("pend_b", 32'h0040_0020, 1, 1);
    pc_stall = 0; Branch_Target = 32'h0000_0600;
    step("br_wins", 32'h0000_0600, 1, 0);
    idle();

    // Misaligned targets are loaded as-is.
    Jump = 1; Jump_Target = 32'h0040_0102;
    step("mis_jmp", 32'h0040_0102, 1, 0);
    idle();
    step("mis_seq", 32'h0040_0106, 1, 0);

    // Wrap past the top of the address space.
    Jump = 1; Jump_Target = 32'hFFFF_FFFC;
    step("top", 32'hFFFF_FFFC, 1, 0);
    idle();
    step("wrap", 32'h0000_0000, 1, 0);

    // Reset pulse mid-run with a pending redirect.
    Jump = 1; Jump_Target = 32'h0000_0100;
    step("pre_rst", 32'h0000_0100, 1, 0);
    pc_stall = 1; Jump = 1; Jump_Target = 32'h0000_0800;
    step("pre_rst_p", 32'h0000_0100, 1, 1);
    #2 Rst = 1;
    #1;
    e = '{"rst_async", 32'hBFC0_0000, 1'b0, 1'b0};
    check_now(e);
    idle();
    @(posedge Clk);
    #1 Rst = 0;
    step("rb1", 32'hBFC0_0000, 0, 0);
    step("rb2", 32'hBFC0_0000, 1, 0);
    step("rb3", 32'hBFC0_0004, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
